// File: rtl/l2_mshr_file.sv
// Non-blocking L2 miss-status holding register file: merges secondary misses per line,
// issues one memory request per line and replays merged targets in arrival order after the fill.
module l2_mshr_file #(
   parameter int unsigned ADDR_WIDTH   = 32,
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned LINE_BITS    = 5,
   parameter int unsigned INDEX_BITS   = 9,
   parameter int unsigned ASSOC_BITS   = 2,
   parameter int unsigned CREG_ID_BITS = 3,
   parameter int unsigned MSHR_ID_BITS = 3,
   parameter int unsigned TGT_BITS     = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    miss_valid,
   output logic                    miss_ready,
   input  logic [ADDR_WIDTH-1:0]   miss_addr,
   input  logic                    miss_rw,
   input  logic [DATA_WIDTH-1:0]   miss_data,
   input  logic [CREG_ID_BITS-1:0] miss_id,
   input  logic [ASSOC_BITS-1:0]   miss_victim,
   input  logic                    miss_dirty,
   output logic                    mem_req_valid,
   input  logic                    mem_req_ready,
   output logic [ADDR_WIDTH-1:0]   mem_req_addr,
   output logic [MSHR_ID_BITS-1:0] mem_req_id,
   output logic [ASSOC_BITS-1:0]   mem_req_victim,
   output logic                    mem_req_dirty,
   input  logic                    fill_valid,
   input  logic [MSHR_ID_BITS-1:0] fill_id,
   output logic                    rp_valid,
   input  logic                    rp_ready,
   output logic [ADDR_WIDTH-1:0]   rp_addr,
   output logic [DATA_WIDTH-1:0]   rp_data,
   output logic                    rp_rw,
   output logic [CREG_ID_BITS-1:0] rp_cpu_id,
   output logic [ASSOC_BITS-1:0]   rp_victim,
   output logic                    rp_last,
   output logic                    empty,
   output logic                    full,
   output logic                    err
);

   localparam int unsigned NUM_ENT = 1 << MSHR_ID_BITS;
   localparam int unsigned NUM_TGT = 1 << TGT_BITS;
   localparam int unsigned TAG_W   = ADDR_WIDTH - LINE_BITS;
   localparam int unsigned CNT_W   = TGT_BITS + 1;

   typedef enum logic [1:0] {ST_FREE, ST_PEND, ST_ISSUED, ST_REPLAY} ent_state_e;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0]   addr;
      logic [DATA_WIDTH-1:0]   data;
      logic                    rw;
      logic [CREG_ID_BITS-1:0] id;
   } tgt_t;

   ent_state_e             state_q [NUM_ENT];
   ent_state_e             state_d [NUM_ENT];
   logic [CNT_W-1:0]       cnt_q   [NUM_ENT];
   logic [CNT_W-1:0]       cnt_d   [NUM_ENT];
   logic [TGT_BITS-1:0]    rptr_q  [NUM_ENT];
   logic [TGT_BITS-1:0]    rptr_d  [NUM_ENT];
   logic [TAG_W-1:0]       line_q  [NUM_ENT];
   logic [ASSOC_BITS-1:0]  victim_q[NUM_ENT];
   logic                   dirty_q [NUM_ENT];
   tgt_t                   tgt_q   [NUM_ENT][NUM_TGT];
   logic                   err_q, err_d;

   logic [TAG_W-1:0]        miss_tag;
   logic [INDEX_BITS-1:0]   miss_set;
   logic                    match_hit, free_hit, pend_hit, rpl_hit, any_live, conflict;
   logic [MSHR_ID_BITS-1:0] match_idx, free_idx, pend_idx, rpl_idx;
   logic                    merge_ok, alloc_ok, do_alloc, do_merge;
   tgt_t                    miss_tgt, rp_tgt;

   assign miss_tag = miss_addr[ADDR_WIDTH-1:LINE_BITS];
   assign miss_set = miss_addr[LINE_BITS+INDEX_BITS-1:LINE_BITS];
   assign miss_tgt = '{addr: miss_addr, data: miss_data, rw: miss_rw, id: miss_id};

   // Associative search; scanning downward leaves the lowest matching index selected.
   always_comb begin
      match_hit = 1'b0;
      match_idx = '0;
      free_hit  = 1'b0;
      free_idx  = '0;
      pend_hit  = 1'b0;
      pend_idx  = '0;
      rpl_hit   = 1'b0;
      rpl_idx   = '0;
      any_live  = 1'b0;
      conflict  = 1'b0;
      for (int i = int'(NUM_ENT) - 1; i >= 0; i--) begin
         if (state_q[i] == ST_FREE) begin
            free_hit = 1'b1;
            free_idx = MSHR_ID_BITS'(i);
         end else begin
            any_live = 1'b1;
            if (line_q[i] == miss_tag) begin
               match_hit = 1'b1;
               match_idx = MSHR_ID_BITS'(i);
            end
            if (line_q[i][INDEX_BITS-1:0] == miss_set && victim_q[i] == miss_victim) begin
               conflict = 1'b1;
            end
         end
         if (state_q[i] == ST_PEND) begin
            pend_hit = 1'b1;
            pend_idx = MSHR_ID_BITS'(i);
         end
         if (state_q[i] == ST_REPLAY) begin
            rpl_hit = 1'b1;
            rpl_idx = MSHR_ID_BITS'(i);
         end
      end
   end

   assign merge_ok   = match_hit
                       && (state_q[match_idx] == ST_PEND || state_q[match_idx] == ST_ISSUED)
                       && (cnt_q[match_idx] < CNT_W'(NUM_TGT));
   assign alloc_ok   = !match_hit && free_hit && !conflict;
   assign miss_ready = merge_ok || alloc_ok;
   assign do_alloc   = miss_valid && alloc_ok;
   assign do_merge   = miss_valid && merge_ok;

   assign rp_tgt = tgt_q[rpl_idx][rptr_q[rpl_idx]];

   // Data outputs are forced to zero whenever the matching valid is low.
   always_comb begin
      mem_req_valid  = pend_hit;
      mem_req_addr   = pend_hit ? {line_q[pend_idx], {LINE_BITS{1'b0}}} : '0;
      mem_req_id     = pend_hit ? pend_idx : '0;
      mem_req_victim = pend_hit ? victim_q[pend_idx] : '0;
      mem_req_dirty  = pend_hit && dirty_q[pend_idx];
      rp_valid       = rpl_hit;
      rp_addr        = rpl_hit ? rp_tgt.addr : '0;
      rp_data        = rpl_hit ? rp_tgt.data : '0;
      rp_rw          = rpl_hit && rp_tgt.rw;
      rp_cpu_id      = rpl_hit ? rp_tgt.id : '0;
      rp_victim      = rpl_hit ? victim_q[rpl_idx] : '0;
      rp_last        = rpl_hit
                       && ({1'b0, rptr_q[rpl_idx]} == cnt_q[rpl_idx] - CNT_W'(1));
      empty          = !any_live;
      full           = !free_hit;
      err            = err_q;
   end

   // Each event only touches entries in a distinct source state, so they never collide.
   always_comb begin
      for (int i = 0; i < int'(NUM_ENT); i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         rptr_d[i]  = rptr_q[i];
      end
      err_d = err_q;

      if (do_alloc) begin
         state_d[free_idx] = ST_PEND;
         cnt_d[free_idx]   = CNT_W'(1);
         rptr_d[free_idx]  = '0;
      end
      if (do_merge) begin
         cnt_d[match_idx] = cnt_q[match_idx] + CNT_W'(1);
      end
      if (mem_req_valid && mem_req_ready) begin
         state_d[pend_idx] = ST_ISSUED;
      end
      if (fill_valid) begin
         if (state_q[fill_id] == ST_ISSUED) begin
            state_d[fill_id] = ST_REPLAY;
         end else begin
            err_d = 1'b1;
         end
      end
      if (rp_valid && rp_ready) begin
         if (rp_last) begin
            state_d[rpl_idx] = ST_FREE;
            cnt_d[rpl_idx]   = '0;
            rptr_d[rpl_idx]  = '0;
         end else begin
            rptr_d[rpl_idx] = rptr_q[rpl_idx] + TGT_BITS'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(NUM_ENT); i++) begin
            state_q[i] <= ST_FREE;
            cnt_q[i]   <= '0;
            rptr_q[i]  <= '0;
         end
         err_q <= 1'b0;
      end else begin
         for (int i = 0; i < int'(NUM_ENT); i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
            rptr_q[i]  <= rptr_d[i];
         end
         err_q <= err_d;
      end
   end

   // Payload storage; only meaningful while the owning entry is live.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (do_alloc) begin
            line_q[free_idx]      <= miss_tag;
            victim_q[free_idx]    <= miss_victim;
            dirty_q[free_idx]     <= miss_dirty;
            tgt_q[free_idx][0]    <= miss_tgt;
         end
         if (do_merge) begin
            tgt_q[match_idx][cnt_q[match_idx][TGT_BITS-1:0]] <= miss_tgt;
         end
      end
   end

endmodule
